// File: rtl/ifid_fetch_buf.sv
// IF->ID pipeline register for a fetch stage driving a synchronous IROM.
// The IROM answers one cycle after the fetch, so the PC is remembered for a
// cycle and then paired with the returned word. A single skid entry parks
// that word when decode is stalled, and flush discards everything held.
module ifid_fetch_buf #(
    parameter int unsigned      ADDR_W       = 32,
    parameter int unsigned      INST_W       = 32,
    parameter int unsigned      STALL_W      = 4,
    parameter int unsigned      ID_STALL_BIT = 2,
    parameter logic [INST_W-1:0] NOP_INST    = '0
) (
    input  logic               cpu_clk_50M,
    input  logic               cpu_rst_n,
    input  logic               ice,
    input  logic [ADDR_W-1:0]  pc,
    input  logic [INST_W-1:0]  inst,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    output logic [ADDR_W-1:0]  id_pc,
    output logic [INST_W-1:0]  id_inst,
    output logic               id_valid,
    output logic               skid_full,
    output logic               ovf_err
);

    // Encoding is {skid occupied, fetch in flight}
    typedef enum logic [1:0] {
        EMPTY     = 2'b00,
        INFL      = 2'b01,
        PARK      = 2'b10,
        PARK_INFL = 2'b11
    } buf_state_t;

    buf_state_t        state;
    logic [ADDR_W-1:0] pend_pc;
    logic [ADDR_W-1:0] skid_pc;
    logic [INST_W-1:0] skid_inst;

    logic pend_v;
    logic skid_v;
    logic adv;
    logic skid_next;
    logic skid_load;

    assign pend_v    = state[0];
    assign skid_v    = state[1];
    assign adv       = ~stall[ID_STALL_BIT];
    assign skid_full = skid_v;

    // Decide whether the skid entry is occupied after the edge and whether
    // the word returning from the IROM this cycle is the one to park there
    always_comb begin
        skid_next = 1'b0;
        skid_load = 1'b0;
        if (flush) begin
            skid_next = 1'b0;
        end else if (adv && skid_v) begin
            skid_next = pend_v;
            skid_load = pend_v;
        end else if (adv) begin
            skid_next = 1'b0;
        end else begin
            skid_next = skid_v | pend_v;
            skid_load = pend_v & ~skid_v;
        end
    end

    // In-flight/skid state, the decode-facing register and the sticky
    // overflow flag; flush beats stall, and the skid drains before new words
    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state     <= EMPTY;
            pend_pc   <= '0;
            skid_pc   <= '0;
            skid_inst <= NOP_INST;
            id_pc     <= '0;
            id_inst   <= NOP_INST;
            id_valid  <= 1'b0;
            ovf_err   <= 1'b0;
        end else begin
            state   <= buf_state_t'({skid_next, ice & ~flush});
            pend_pc <= pc;
            if (skid_load) begin
                skid_pc   <= pend_pc;
                skid_inst <= inst;
            end
            if (flush) begin
                id_valid <= 1'b0;
                id_pc    <= '0;
                id_inst  <= NOP_INST;
            end else if (adv && skid_v) begin
                id_valid <= 1'b1;
                id_pc    <= skid_pc;
                id_inst  <= skid_inst;
            end else if (adv && pend_v) begin
                id_valid <= 1'b1;
                id_pc    <= pend_pc;
                id_inst  <= inst;
            end else if (adv) begin
                id_valid <= 1'b0;
                id_pc    <= '0;
                id_inst  <= NOP_INST;
            end else if (pend_v && skid_v) begin
                ovf_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ifid_fetch_buf.sv
// Randomised and directed bench for ifid_fetch_buf against a queue-based
// model of the fetch buffer: words in arrival order, at most one parked.
module tb_ifid_fetch_buf;

    logic        cpu_clk_50M = 1'b0;
    logic        cpu_rst_n   = 1'b0;
    logic        ice         = 1'b0;
    logic [31:0] pc          = '0;
    logic [31:0] inst        = '0;
    logic [3:0]  stall       = '0;
    logic        flush       = 1'b0;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_valid;
    logic        skid_full;
    logic        ovf_err;

    int check_cnt = 0;
    int pass_cnt  = 0;

    // Reference model state
    logic        m_pend;
    logic [31:0] m_pend_pc;
    logic [63:0] m_skid[$];
    logic        m_out_v;
    logic [31:0] m_out_pc;
    logic [31:0] m_out_inst;
    logic        m_ovf;

    ifid_fetch_buf dut (
        .cpu_clk_50M (cpu_clk_50M),
        .cpu_rst_n   (cpu_rst_n),
        .ice         (ice),
        .pc          (pc),
        .inst        (inst),
        .stall       (stall),
        .flush       (flush),
        .id_pc       (id_pc),
        .id_inst     (id_inst),
        .id_valid    (id_valid),
        .skid_full   (skid_full),
        .ovf_err     (ovf_err)
    );

    always #5 cpu_clk_50M = ~cpu_clk_50M;

    function automatic logic [31:0] irom(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h1234_5678;
    endfunction

    task automatic model_reset();
        m_pend     = 1'b0;
        m_pend_pc  = '0;
        m_skid.delete();
        m_out_v    = 1'b0;
        m_out_pc   = '0;
        m_out_inst = '0;
        m_ovf      = 1'b0;
    endtask

    // One clock: drive inputs, let the edge happen, advance the model
    task automatic cycle(input logic ice_i, input logic [31:0] pc_i,
                         input logic [3:0] stall_i, input logic flush_i);
        logic [63:0] avail[$];
        logic        have_r;
        logic [63:0] r;
        ice   = ice_i;
        pc    = pc_i;
        stall = stall_i;
        flush = flush_i;
        inst  = m_pend ? irom(m_pend_pc) : $urandom;
        @(posedge cpu_clk_50M);
        have_r = m_pend;
        r      = {m_pend_pc, inst};
        if (flush_i) begin
            m_skid.delete();
            m_out_v = 1'b0; m_out_pc = '0; m_out_inst = '0;
        end else if (!stall_i[2]) begin
            avail = m_skid;
            if (have_r) avail.push_back(r);
            if (avail.size() > 0) begin
                r = avail.pop_front();
                m_out_v = 1'b1; m_out_pc = r[63:32]; m_out_inst = r[31:0];
            end else begin
                m_out_v = 1'b0; m_out_pc = '0; m_out_inst = '0;
            end
            m_skid = avail;
        end else if (have_r) begin
            if (m_skid.size() == 0) m_skid.push_back(r);
            else m_ovf = 1'b1;
        end
        m_pend    = ice_i & ~flush_i;
        m_pend_pc = pc_i;
        #1;
    endtask

    task automatic test_reset();
        model_reset();
        #12;
        check_cnt++;
        if ({id_valid, id_pc, id_inst, skid_full, ovf_err} !== 67'd0)
            $display("[TB] FAIL reset_state: got v=%b pc=%h inst=%h skid=%b ovf=%b, need all zero",
                     id_valid, id_pc, id_inst, skid_full, ovf_err);
        else pass_cnt++;
        cpu_rst_n = 1'b1;
    endtask

    task automatic test_stream();
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 32'(i * 4), 4'b0000, 1'b0);
            check_cnt++;
            if ({id_valid, id_pc, id_inst, skid_full, ovf_err} !==
                {m_out_v, m_out_pc, m_out_inst, m_skid.size() == 1, m_ovf})
                $display("[TB] FAIL stream[%0d]: got v=%b pc=%h inst=%h, need v=%b pc=%h inst=%h",
                         i, id_valid, id_pc, id_inst, m_out_v, m_out_pc, m_out_inst);
            else pass_cnt++;
            if (i == 1) begin
                check_cnt++;
                if ({id_valid, id_pc, id_inst} !== {1'b1, 32'h0, irom(32'h0)})
                    $display("[TB] FAIL stream_first: got v=%b pc=%h inst=%h, need v=1 pc=0 inst=%h",
                             id_valid, id_pc, id_inst, irom(32'h0));
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i <= 4; i++) cycle(1'b1, 32'(i * 4), 4'b0000, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 32'h0, 4'b0100, 1'b0);
            check_cnt++;
            if ({id_valid, id_pc, skid_full} !== {1'b1, 32'h0C, 1'b1})
                $display("[TB] FAIL stall_hold[%0d]: got v=%b pc=%h skid=%b, need v=1 pc=0000000c skid=1",
                         i, id_valid, id_pc, skid_full);
            else pass_cnt++;
        end
        cycle(1'b1, 32'h14, 4'b0000, 1'b0);
        check_cnt++;
        if ({id_pc, id_inst} !== {32'h10, irom(32'h10)})
            $display("[TB] FAIL stall_release: got pc=%h inst=%h, need pc=00000010 inst=%h",
                     id_pc, id_inst, irom(32'h10));
        else pass_cnt++;
        cycle(1'b1, 32'h18, 4'b0000, 1'b0);
        check_cnt++;
        if ({id_valid, id_pc, skid_full} !== {1'b1, 32'h14, 1'b0})
            $display("[TB] FAIL stall_next: got v=%b pc=%h skid=%b, need v=1 pc=00000014 skid=0",
                     id_valid, id_pc, skid_full);
        else pass_cnt++;
    endtask

    task automatic test_flush();
        cycle(1'b1, 32'h20, 4'b0000, 1'b0);
        cycle(1'b0, 32'h0, 4'b0100, 1'b1);
        check_cnt++;
        if ({id_valid, id_inst, id_pc, skid_full} !== 66'd0)
            $display("[TB] FAIL flush: got v=%b pc=%h inst=%h skid=%b, need all zero",
                     id_valid, id_pc, id_inst, skid_full);
        else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 32'h0, 4'b0000, 1'b0);
            check_cnt++;
            if (id_valid !== 1'b0 || id_pc === 32'h20)
                $display("[TB] FAIL flush_after[%0d]: got v=%b pc=%h, need v=0 pc!=00000020",
                         i, id_valid, id_pc);
            else pass_cnt++;
        end
    endtask

    task automatic test_overflow();
        cycle(1'b1, 32'h30, 4'b0100, 1'b0);
        cycle(1'b1, 32'h34, 4'b0100, 1'b0);
        cycle(1'b0, 32'h0,  4'b0100, 1'b0);
        check_cnt++;
        if ({ovf_err, skid_full} !== 2'b11)
            $display("[TB] FAIL overflow_flag: got ovf=%b skid=%b, need ovf=1 skid=1", ovf_err, skid_full);
        else pass_cnt++;
        cycle(1'b0, 32'h0, 4'b0000, 1'b0);
        check_cnt++;
        if ({id_valid, id_pc, id_inst} !== {1'b1, 32'h30, irom(32'h30)})
            $display("[TB] FAIL overflow_kept: got v=%b pc=%h inst=%h, need v=1 pc=00000030",
                     id_valid, id_pc, id_inst);
        else pass_cnt++;
        for (int i = 0; i < 2; i++) begin
            cycle(1'b0, 32'h0, 4'b0000, 1'b0);
            check_cnt++;
            if ({id_valid, ovf_err} !== 2'b01)
                $display("[TB] FAIL overflow_sticky[%0d]: got v=%b ovf=%b, need v=0 ovf=1 (0x34 dropped)",
                         i, id_valid, ovf_err);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid();
        cycle(1'b1, 32'h40, 4'b0100, 1'b0);
        cycle(1'b0, 32'h0,  4'b0100, 1'b0);
        check_cnt++;
        if (skid_full !== 1'b1)
            $display("[TB] FAIL reset_mid_setup: got skid=%b, need 1", skid_full);
        else pass_cnt++;
        #2 cpu_rst_n = 1'b0;
        #1;
        check_cnt++;
        if ({id_valid, id_pc, id_inst, skid_full, ovf_err} !== 67'd0)
            $display("[TB] FAIL reset_mid: got v=%b pc=%h inst=%h skid=%b ovf=%b, need all zero",
                     id_valid, id_pc, id_inst, skid_full, ovf_err);
        else pass_cnt++;
        model_reset();
        @(posedge cpu_clk_50M);
        #1 cpu_rst_n = 1'b1;
        cycle(1'b0, 32'h0, 4'b0000, 1'b0);
        check_cnt++;
        if ({id_valid, skid_full} !== 2'b00)
            $display("[TB] FAIL reset_release: got v=%b skid=%b, need v=0 skid=0", id_valid, skid_full);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        cycle(1'b1, 32'h50, 4'b0000, 1'b0);
        cycle(1'b1, 32'h54, 4'b0100, 1'b0);
        cycle(1'b0, 32'h0,  4'b0000, 1'b0);
        check_cnt++;
        if ({id_valid, id_pc, id_inst, skid_full} !== {1'b1, 32'h50, irom(32'h50), 1'b1})
            $display("[TB] FAIL b2b_first: got v=%b pc=%h skid=%b, need v=1 pc=00000050 skid=1",
                     id_valid, id_pc, skid_full);
        else pass_cnt++;
        cycle(1'b0, 32'h0, 4'b0000, 1'b0);
        check_cnt++;
        if ({id_valid, id_pc, id_inst, skid_full, ovf_err} !== {1'b1, 32'h54, irom(32'h54), 1'b0, 1'b0})
            $display("[TB] FAIL b2b_second: got v=%b pc=%h skid=%b ovf=%b, need v=1 pc=00000054 skid=0 ovf=0",
                     id_valid, id_pc, skid_full, ovf_err);
        else pass_cnt++;
    endtask

    task automatic test_random();
        logic [3:0] st;
        for (int i = 0; i < 400; i++) begin
            st = 4'($urandom);
            if ($urandom_range(0, 2) != 0) st[2] = 1'b0;
            cycle(1'($urandom), {$urandom_range(0, 255), 2'b00}, st,
                  $urandom_range(0, 19) == 0);
            check_cnt++;
            if ({id_valid, id_pc, id_inst, skid_full, ovf_err} !==
                {m_out_v, m_out_pc, m_out_inst, m_skid.size() == 1, m_ovf})
                $display("[TB] FAIL random[%0d]: got v=%b pc=%h inst=%h skid=%b ovf=%b, need v=%b pc=%h inst=%h skid=%b ovf=%b",
                         i, id_valid, id_pc, id_inst, skid_full, ovf_err,
                         m_out_v, m_out_pc, m_out_inst, m_skid.size() == 1, m_ovf);
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_flush();
        test_overflow();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
